fft_input_framer: RTL and testbench
===================================

// Module: fft_input_framer
// PURPOSE
//  Streaming-to-frame loader in front of the 8-point FFT core. Accepts one complex sample per
//  valid/ready beat. Writes each sample into a ping-pong frame buffer at its bit-reversed index.
//  Presents each completed N-sample frame as a parallel array with a valid/ready handshake.
//  Output feeds the core's first butterfly stage.
// PARAMETERS
//  DATA_W   50  sample width: {re[DATA_W/2-1:0], im[DATA_W/2-1:0]}, both signed; passed through untouched
//  LOG2N    3   log2 of frame length; N = 2**LOG2N = 8
//  CNT_W    16  width of the completed-frame counter
// PORTS
//  clk_i          in   1             single clock; all logic on rising edge
//  rst_i          in   1             asynchronous, active-low reset
//  s_valid_i      in   1             input sample valid
//  s_data_i       in   DATA_W        input sample
//  s_ready_o      out  1             framer can accept a sample this cycle
//  flush_i        in   1             sync: discard the partially filled frame
//  frame_o        out  DATA_W x N    frame, [0:N-1], already in bit-reversed order
//  frame_valid_o  out  1             frame_o holds a complete frame
//  frame_ready_i  in   1             consumer takes frame_o this cycle
//  overflow_o     out  1             sticky: s_valid_i seen while s_ready_o=0
//  frame_cnt_o    out  CNT_W         frames delivered (valid&ready beats); wraps at 2**CNT_W
// BEHAVIOUR
//  Reset (rst_i=0, async): wr_bank=0, rd_bank=0, idx=0, full[1:0]=0.
//   Both banks' storage = 0, so frame_o=0. frame_valid_o=0, s_ready_o=1, overflow_o=0, frame_cnt_o=0.
//   Reset mid-frame discards all stored data; the first beat after release is index 0.
//  Accept: beat = s_valid_i & s_ready_o.
//   A beat writes bank[wr_bank][bitrev(idx)] <= s_data_i, then idx++.
//  Frame completion: a beat with idx==N-1 sets full[wr_bank]=1, toggles wr_bank and sets idx=0.
//  s_ready_o = !full[wr_bank]. It is register-derived only; there is no combinational path from
//   frame_ready_i or s_valid_i.
//  Output: frame_valid_o = full[rd_bank]; frame_o = bank[rd_bank].
//   frame_o is stable while frame_valid_o=1 and frame_ready_i=0.
//   Take = frame_valid_o & frame_ready_i. On a take: clear full[rd_bank], toggle rd_bank, frame_cnt_o++.
//  Latency: if the last sample of a frame is accepted at cycle t, frame_valid_o=1 at t+1.
//   A take at cycle t frees that bank for writing at t+1.
//  Both banks full: s_ready_o=0; idx holds; no write.
//  Simultaneous completion and take on different banks: both take effect in the same cycle.
//   Throughput is 1 sample/cycle sustained when frame_ready_i=1.
//  Overflow: s_valid_i=1 & s_ready_o=0 sets overflow_o. The sample is dropped. Cleared by reset only.
//  Flush: flush_i=1 sets idx=0. A beat in the same cycle is discarded (no write, no idx++).
//   Full banks, rd_bank and the output handshake are unaffected.
//   Stale data in the partial bank is overwritten by the next frame.
//  Bit reversal: N=8 maps idx 0..7 -> slots 0,4,2,6,1,5,3,7.
//  No arithmetic on samples; widths are preserved exactly.
// STRUCTURE
//  Shared package fft_pkg contains:
//   - localparams FFT_LOG2N=3, FFT_N=8, FFT_DATA_W=50
//   - typedef logic [FFT_DATA_W-1:0] fft_sample_t
//   - typedef fft_sample_t fft_frame_t [0:FFT_N-1]
//   - function bitrev(idx, LOG2N)
//  Sub-module fft_frame_bank: one N-entry register bank with write enable, write address and
//   write data, a full flag, and a full-array read port. Instantiated twice.
//  Top level holds idx, wr_bank, rd_bank, the handshake logic, overflow_o and frame_cnt_o.
// TESTING
//  1 Reset, then samples 0..7 (value=index) with frame_ready_i=1 -> frame_valid_o at cycle after 8th beat;
//    frame_o = {0,4,2,6,1,5,3,7}; frame_cnt_o=1.
//  2 Hold frame_ready_i=0 and stream 24 samples -> s_ready_o falls after beat 16; frame_o stable;
//    overflow_o=1 if s_valid_i held; frames 1,2 then delivered in order once ready rises.
//  3 Continuous 64 samples, frame_ready_i=1 always -> s_ready_o never 0; 8 frames back-to-back;
//    frame_cnt_o=8; overflow_o=0.
//  4 Send 5 samples, pulse flush_i with s_valid_i=1, then 8 samples 100..107 ->
//    frame = bitrev order of 100..107; the 5 partial samples and the flush-cycle sample never appear.
//  5 Assert rst_i=0 after 3 samples of frame 2 while frame 1 is pending -> all outputs at reset values;
//    next 8 samples form frame_cnt_o=1's frame.
//  6 frame_cnt_o preloaded near wrap (force, CNT_W=16) -> 0xFFFF + take = 0x0000; handshake unaffected.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT input path.
package fft_pkg;

    localparam int FFT_LOG2N  = 3;
    localparam int FFT_N      = 2 ** FFT_LOG2N;
    localparam int FFT_DATA_W = 50;

    typedef logic [FFT_DATA_W-1:0] fft_sample_t;
    typedef fft_sample_t fft_frame_t [0:FFT_N-1];

    // Reverse the low log2n bits of idx; bits above log2n are ignored.
    function automatic int bitrev(input int idx, input int log2n);
        int r;
        int v;
        r = 0;
        v = idx;
        for (int i = 0; i < 32; i++) begin
            if (i < log2n) begin
                r = (r << 1) | (v & 1);
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One N-entry sample bank with a single write port, a full flag and a full-array read port.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int LOG2N  = FFT_LOG2N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [LOG2N-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              set_full,
    input  logic              clr_full,
    output logic              full,
    output logic [DATA_W-1:0] rd_data [0:(2**LOG2N)-1]
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            for (int k = 0; k < 2 ** LOG2N; k++) begin
                rd_data[k] <= '0;
            end
        end else begin
            if (wr_en) begin
                rd_data[wr_addr] <= wr_data;
            end
            // set and clear never target the same bank in one cycle
            if (set_full) begin
                full <= 1'b1;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fft_input_framer.sv
// Streams complex samples into a ping-pong pair of banks at bit-reversed slots and hands out whole frames.
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int LOG2N  = FFT_LOG2N,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              s_ready_o,
    input  logic              flush_i,
    output logic [DATA_W-1:0] frame_o [0:(2**LOG2N)-1],
    output logic              frame_valid_o,
    input  logic              frame_ready_i,
    output logic              overflow_o,
    output logic [CNT_W-1:0]  frame_cnt_o
);

    localparam int N = 2 ** LOG2N;

    logic [LOG2N-1:0]  idx;
    logic [LOG2N-1:0]  wr_addr;
    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        full;
    logic              beat;
    logic              wr_ok;
    logic              last;
    logic              take;
    logic [DATA_W-1:0] bank0_data [0:N-1];
    logic [DATA_W-1:0] bank1_data [0:N-1];

    // Ready depends only on registered state, never on s_valid_i or frame_ready_i.
    assign s_ready_o     = ~full[wr_bank];
    assign frame_valid_o = full[rd_bank];
    assign beat          = s_valid_i & s_ready_o;
    assign wr_ok         = beat & ~flush_i;
    assign last          = wr_ok & (&idx);
    assign take          = frame_valid_o & frame_ready_i;
    assign wr_addr       = LOG2N'(bitrev(int'(idx), LOG2N));

    fft_frame_bank #(.DATA_W(DATA_W), .LOG2N(LOG2N)) u_bank0 (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .wr_en    (wr_ok & ~wr_bank),
        .wr_addr  (wr_addr),
        .wr_data  (s_data_i),
        .set_full (last & ~wr_bank),
        .clr_full (take & ~rd_bank),
        .full     (full[0]),
        .rd_data  (bank0_data)
    );

    fft_frame_bank #(.DATA_W(DATA_W), .LOG2N(LOG2N)) u_bank1 (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .wr_en    (wr_ok & wr_bank),
        .wr_addr  (wr_addr),
        .wr_data  (s_data_i),
        .set_full (last & wr_bank),
        .clr_full (take & rd_bank),
        .full     (full[1]),
        .rd_data  (bank1_data)
    );

    always_comb begin
        for (int k = 0; k < N; k++) begin
            frame_o[k] = rd_bank ? bank1_data[k] : bank0_data[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx         <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            overflow_o  <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            // A flush wins over a same-cycle beat: the sample is dropped and the frame restarts.
            if (flush_i) begin
                idx <= '0;
            end else if (wr_ok) begin
                idx <= idx + 1'b1;
            end
            if (last) begin
                wr_bank <= ~wr_bank;
            end
            if (s_valid_i && !s_ready_o) begin
                overflow_o <= 1'b1;
            end
            if (take) begin
                rd_bank     <= ~rd_bank;
                frame_cnt_o <= frame_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_input_framer.sv
// Self-checking bench: vector table, directed corner sequences and random traffic against a frame-queue model.
module tb_fft_input_framer;

    localparam int DW = 50;
    localparam int N  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          s_valid_i;
    logic [DW-1:0] s_data_i;
    logic          s_ready_o;
    logic          flush_i;
    logic [DW-1:0] frame_o [0:N-1];
    logic          frame_valid_o;
    logic          frame_ready_i;
    logic          overflow_o;
    logic [CW-1:0] frame_cnt_o;

    always #5 clk = ~clk;

    fft_input_framer #(.DATA_W(DW), .LOG2N(3), .CNT_W(CW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .s_valid_i     (s_valid_i),
        .s_data_i      (s_data_i),
        .s_ready_o     (s_ready_o),
        .flush_i       (flush_i),
        .frame_o       (frame_o),
        .frame_valid_o (frame_valid_o),
        .frame_ready_i (frame_ready_i),
        .overflow_o    (overflow_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    // Reference model: a queue of completed frames (at most two) plus the frame being filled.
    typedef struct { logic [DW-1:0] s [N]; } mframe_t;
    mframe_t       pend[$];
    mframe_t       part;
    int            fill;
    bit            m_ovf;
    logic [CW-1:0] m_cnt;
    int            rev [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit            sv;
        logic [DW-1:0] d;
        bit            fr;
        bit            e_ready;
        bit            e_valid;
        logic [CW-1:0] e_cnt;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom, $urandom});
    endfunction

    task automatic model_reset();
        pend.delete();
        fill  = 0;
        m_ovf = 1'b0;
        m_cnt = '0;
        for (int k = 0; k < N; k++) part.s[k] = '0;
    endtask

    task automatic drive(input bit sv, input logic [DW-1:0] d, input bit fl, input bit fr);
        @(negedge clk);
        s_valid_i     = sv;
        s_data_i      = d;
        flush_i       = fl;
        frame_ready_i = fr;
        #1;
    endtask

    task automatic check_and_clock();
        bit            ready, valid, take, sv, fl;
        logic [DW-1:0] d;
        ready = pend.size() < 2;
        valid = pend.size() > 0;
        chk("s_ready", 64'(s_ready_o), 64'(ready));
        chk("frame_valid", 64'(frame_valid_o), 64'(valid));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        chk("frame_cnt", 64'(frame_cnt_o), 64'(m_cnt));
        if (valid) begin
            for (int k = 0; k < N; k++) chk($sformatf("frame[%0d]", k), 64'(frame_o[k]), 64'(pend[0].s[k]));
        end
        take = valid & frame_ready_i;
        sv   = s_valid_i;
        fl   = flush_i;
        d    = s_data_i;
        @(posedge clk);
        if (sv && !ready) m_ovf = 1'b1;
        if (take) begin
            void'(pend.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        if (fl) begin
            fill = 0;
        end else if (sv && ready) begin
            part.s[rev[fill]] = d;
            fill++;
            if (fill == N) begin
                pend.push_back(part);
                fill = 0;
            end
        end
    endtask

    task automatic step(input bit sv, input logic [DW-1:0] d, input bit fl, input bit fr);
        drive(sv, d, fl, fr);
        check_and_clock();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i         = 1'b0;
        s_valid_i     = 1'b0;
        s_data_i      = '0;
        flush_i       = 1'b0;
        frame_ready_i = 1'b0;
        #1;
        model_reset();
        chk("rst_ready", 64'(s_ready_o), 64'd1);
        chk("rst_valid", 64'(frame_valid_o), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_cnt", 64'(frame_cnt_o), 64'd0);
        for (int k = 0; k < N; k++) chk($sformatf("rst_frame[%0d]", k), 64'(frame_o[k]), 64'd0);
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    initial begin
        logic [CW-1:0] cnt0;
        rst_i = 1'b1;
        s_valid_i = 1'b0;
        s_data_i = '0;
        flush_i = 1'b0;
        frame_ready_i = 1'b0;
        model_reset();

        // Test 1: samples 0..7 as a table; expectations are the values seen before each clock edge.
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, DW'(i), 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[8] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 16'd0};
        tbl[9] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, 16'd1};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].sv, tbl[i].d, 1'b0, tbl[i].fr);
            chk($sformatf("t1_ready[%0d]", i), 64'(s_ready_o), 64'(tbl[i].e_ready));
            chk($sformatf("t1_valid[%0d]", i), 64'(frame_valid_o), 64'(tbl[i].e_valid));
            chk($sformatf("t1_cnt[%0d]", i), 64'(frame_cnt_o), 64'(tbl[i].e_cnt));
            if (i == 8) begin
                for (int k = 0; k < N; k++) chk($sformatf("t1_frame[%0d]", k), 64'(frame_o[k]), 64'(rev[k]));
            end
            check_and_clock();
        end

        // Test 2: consumer stalled while 24 samples arrive; then both frames drain in order.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, rnd(), 1'b0, 1'b0);
            if (i == 16) chk("t2_ready_low", 64'(s_ready_o), 64'd0);
            check_and_clock();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t2_overflow", 64'(overflow_o), 64'd1);
        check_and_clock();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk("t2_cnt", 64'(frame_cnt_o), 64'd2);

        // Test 3: 64 back-to-back samples with the consumer always ready.
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, rnd(), 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk("t3_cnt", 64'(frame_cnt_o), 64'd8);
        chk("t3_overflow", 64'(overflow_o), 64'd0);

        // Test 4: partial frame, flush with a valid sample, then 100..107.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, DW'(50 + i), 1'b0, 1'b0);
        step(1'b1, DW'(77), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, DW'(100 + i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) chk($sformatf("t4_frame[%0d]", k), 64'(frame_o[k]), 64'(100 + rev[k]));
        check_and_clock();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Test 5: reset while frame 1 is pending and frame 2 is partial.
        do_reset();
        for (int i = 0; i < 11; i++) step(1'b1, rnd(), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, DW'(200 + i), 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("t5_first", 64'(frame_o[1]), 64'(204));
        check_and_clock();
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t5_cnt", 64'(frame_cnt_o), 64'd1);

        // Test 6: frame counter preloaded one below wrap.
        do_reset();
        @(negedge clk);
        force dut.frame_cnt_o = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_o;
        m_cnt = 16'hFFFF;
        for (int i = 0; i < 8; i++) step(1'b1, rnd(), 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t6_wrap", 64'(frame_cnt_o), 64'd0);
        for (int i = 0; i < 8; i++) step(1'b1, rnd(), 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t6_after_wrap", 64'(frame_cnt_o), 64'd1);

        // Random traffic: bursty valid, occasional flush, intermittent consumer.
        do_reset();
        cnt0 = frame_cnt_o;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk("rand_cnt", 64'(frame_cnt_o - cnt0), 64'(m_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
